// File: rtl/bsu_phase_loader.sv
// Phase loader: reads each element's phase from the shared LUT bus and shifts the
// words out to the phase-shifter chain. Define BSU_PARITY_EN to append an odd-parity bit per word.
module bsu_phase_loader #(
  parameter int N_ELEM  = 8,
  parameter int PH_W    = 5,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        teta_in,
  input  logic [1:0]        piv_in,
  output logic [3:0]        lut_teta,
  output logic [1:0]        lut_piv,
  output logic [N_ELEM-1:0] lut_en,
  input  logic [PH_W-1:0]   lut_phase,
  output logic              ser_clk,
  output logic              ser_data,
  output logic              ser_le,
  output logic              busy,
  output logic              done
);

`ifdef BSU_PARITY_EN
  localparam int WORD_W = PH_W + 1;
`else
  localparam int WORD_W = PH_W;
`endif
  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_CAPT,
    S_SHIFT,
    S_LATCH,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        teta_q, teta_d;
  logic [1:0]        piv_q, piv_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              half_q, half_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      teta_q  <= '0;
      piv_q   <= '0;
      idx_q   <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      half_q  <= 1'b0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      teta_q  <= teta_d;
      piv_q   <= piv_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      half_q  <= half_d;
      sreg_q  <= sreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    teta_d   = teta_q;
    piv_d    = piv_q;
    idx_d    = idx_q;
    bit_d    = bit_q;
    div_d    = div_q;
    half_d   = half_q;
    sreg_d   = sreg_q;
    lut_en   = '0;
    ser_clk  = 1'b0;
    ser_data = 1'b0;
    ser_le   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          teta_d  = teta_in;
          piv_d   = piv_in;
          idx_d   = LAST_IDX;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        lut_en  = N_ELEM'(1) << idx_q;
        state_d = S_CAPT;
      end
      S_CAPT: begin
        lut_en  = N_ELEM'(1) << idx_q;
`ifdef BSU_PARITY_EN
        sreg_d  = {lut_phase, ~^lut_phase};
`else
        sreg_d  = lut_phase;
`endif
        bit_d   = '0;
        div_d   = '0;
        half_d  = 1'b0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        ser_clk  = half_q;
        ser_data = sreg_q[WORD_W-1];
        // Each bit is CLK_DIV cycles low then CLK_DIV cycles high; the word advances on the falling edge.
        if (div_q == LAST_DIV) begin
          div_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            sreg_d = sreg_q << 1;
            if (bit_q == LAST_BIT) begin
              if (idx_q != '0) begin
                idx_d   = idx_q - IDX_W'(1);
                state_d = S_SEL;
              end else begin
                state_d = S_LATCH;
              end
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_LATCH: begin
        ser_le = 1'b1;
        if (div_q == LAST_DIV) begin
          div_d   = '0;
          state_d = S_DONE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign lut_teta = teta_q;
  assign lut_piv  = piv_q;

endmodule

// File: tb/tb_bsu_phase_loader.sv
// Randomized bench for bsu_phase_loader: stub LUT bus plus a bit-stream reference model.
// Honours BSU_PARITY_EN when building the expected stream.
module tb_bsu_phase_loader;

  localparam int N       = 8;
  localparam int PH_W    = 5;
  localparam int CLK_DIV = 4;
`ifdef BSU_PARITY_EN
  localparam int BPW = PH_W + 1;
`else
  localparam int BPW = PH_W;
`endif
  localparam int FRAME_LEN = N * (2 + 2 * BPW * CLK_DIV) + CLK_DIV + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [3:0]      teta_in;
  logic [1:0]      piv_in;
  logic [3:0]      lut_teta;
  logic [1:0]      lut_piv;
  logic [N-1:0]    lut_en;
  logic [PH_W-1:0] lut_phase;
  logic            ser_clk;
  logic            ser_data;
  logic            ser_le;
  logic            busy;
  logic            done;

  logic [PH_W-1:0] phase_tab [N];
  logic [3:0]      exp_teta;
  logic [1:0]      exp_piv;

  int n_checks = 0;
  int n_fail   = 0;

  int busy_cnt, le_cnt, en_cycles, teta_bad, gap_cnt, last_gap;
  int frames_done = 0;
  bit bits[$];
  logic prev_clk, prev_busy;

  bsu_phase_loader #(.N_ELEM(N), .PH_W(PH_W), .CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .teta_in   (teta_in),
    .piv_in    (piv_in),
    .lut_teta  (lut_teta),
    .lut_piv   (lut_piv),
    .lut_en    (lut_en),
    .lut_phase (lut_phase),
    .ser_clk   (ser_clk),
    .ser_data  (ser_data),
    .ser_le    (ser_le),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Stub LUTs: the enabled element drives its table entry onto the shared bus.
  always_comb begin
    lut_phase = '0;
    for (int i = 0; i < N; i++)
      if (lut_en[i]) lut_phase = phase_tab[i];
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Expected stream: elements N-1 down to 0, each word MSB first, optional odd parity after it.
  task automatic checkFrame();
    bit expq[$];
    logic [63:0] act_w, exp_w;
    expq = {};
    for (int e = N - 1; e >= 0; e--) begin
      for (int b = PH_W - 1; b >= 0; b--) expq.push_back(phase_tab[e][b]);
`ifdef BSU_PARITY_EN
      expq.push_back(~^phase_tab[e]);
`endif
    end
    checkOutput("busy_len", 64'(busy_cnt), 64'(FRAME_LEN));
    checkOutput("ser_clk_edges", 64'(bits.size()), 64'(expq.size()));
    for (int w = 0; w < N; w++) begin
      act_w = '0;
      exp_w = '0;
      for (int b = 0; b < BPW; b++) begin
        act_w = {act_w[62:0], ((w * BPW + b) < bits.size()) ? bits[w * BPW + b] : 1'b0};
        exp_w = {exp_w[62:0], expq[w * BPW + b]};
      end
      checkOutput($sformatf("word%0d", w), act_w, exp_w);
    end
    checkOutput("ser_le_len", 64'(le_cnt), 64'(CLK_DIV));
    checkOutput("lut_en_cycles", 64'(en_cycles), 64'(2 * N));
    checkOutput("steer_held", 64'(teta_bad), 64'(0));
    checkOutput("steer_value", {58'(0), lut_teta, lut_piv}, {58'(0), exp_teta, exp_piv});
  endtask

  // Cycle monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      bits = {};
      busy_cnt = 0; le_cnt = 0; en_cycles = 0; teta_bad = 0; gap_cnt = 0;
      prev_clk = 1'b0; prev_busy = 1'b0;
    end else begin
      int elem;
      if (busy && !prev_busy) begin
        last_gap = gap_cnt;
        gap_cnt = 0;
        bits = {};
        busy_cnt = 0; le_cnt = 0; en_cycles = 0; teta_bad = 0;
      end
      if (!busy) gap_cnt++;
      checkOutput("lut_en_onehot", 64'($countones(lut_en) > 1), 64'(0));
      if (lut_en != '0) begin
        en_cycles++;
        elem = N - 1 - bits.size() / BPW;
        checkOutput("lut_en_sel", 64'(lut_en), (elem >= 0) ? (64'(1) << elem) : 64'(0));
      end
      if (busy) begin
        busy_cnt++;
        if (lut_teta !== exp_teta || lut_piv !== exp_piv) teta_bad++;
      end
      if (ser_clk && !prev_clk) bits.push_back(ser_data);
      if (ser_le) begin
        le_cnt++;
        checkOutput("ser_le_after_last_bit", 64'(bits.size()), 64'(N * BPW));
      end
      if (done) begin
        frames_done++;
        checkFrame();
      end
      prev_clk = ser_clk;
      prev_busy = busy;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] t, input logic [1:0] p);
    tick();
    teta_in = t;
    piv_in = p;
    exp_teta = t;
    exp_piv = p;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone();
    int base;
    int n;
    base = frames_done;
    n = 0;
    while (frames_done == base && n < FRAME_LEN + 50) begin
      tick();
      n++;
    end
    if (frames_done == base) checkOutput("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic waitBits(input int count);
    int n;
    n = 0;
    while (bits.size() < count && n < FRAME_LEN + 50) begin
      tick();
      n++;
    end
    if (bits.size() < count) checkOutput("bits_timeout", 64'(bits.size()), 64'(count));
  endtask

  task automatic randomPhases();
    for (int i = 0; i < N; i++) phase_tab[i] = PH_W'($urandom_range(0, (1 << PH_W) - 1));
  endtask

  initial begin
    int idle_activity;
    rst_n = 1'b0;
    start = 1'b1;
    teta_in = 4'h0;
    piv_in = 2'b00;
    exp_teta = 4'h0;
    exp_piv = 2'b00;
    for (int i = 0; i < N; i++) phase_tab[i] = PH_W'(i + 1);

    $display("[TB] reset with start held");
    repeat (3) tick();
    checkOutput("reset_outputs",
                64'({lut_teta, lut_piv, lut_en, ser_clk, ser_data, ser_le, busy, done}), 64'(0));
    start = 1'b0;
    rst_n = 1'b1;

    $display("[TB] nominal frame, phase k+1");
    applyStimulus(4'h9, 2'b10);
    waitDone();

    $display("[TB] start ignored while busy");
    applyStimulus(4'h9, 2'b10);
    waitBits(3);
    teta_in = 4'h3;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone();

    $display("[TB] reset during third element shift");
    randomPhases();
    applyStimulus(4'(($urandom)), 2'(($urandom)));
    waitBits(2 * BPW + 2);
    rst_n = 1'b0;
    tick();
    checkOutput("abort_outputs",
                64'({lut_teta, lut_piv, lut_en, ser_clk, ser_data, ser_le, busy, done}), 64'(0));
    rst_n = 1'b1;
    idle_activity = 0;
    repeat (60) begin
      tick();
      if (ser_le || busy) idle_activity++;
    end
    checkOutput("no_le_after_abort", 64'(idle_activity), 64'(0));
    applyStimulus(4'(($urandom)), 2'(($urandom)));
    waitDone();

    $display("[TB] start held for two frames");
    tick();
    teta_in = 4'h6;
    piv_in = 2'b01;
    exp_teta = 4'h6;
    exp_piv = 2'b01;
    start = 1'b1;
    waitDone();
    waitDone();
    start = 1'b0;
    checkOutput("frame_gap", 64'(last_gap), 64'(1));

    $display("[TB] all-zero phases");
    for (int i = 0; i < N; i++) phase_tab[i] = '0;
    applyStimulus(4'hF, 2'b11);
    waitDone();

    $display("[TB] random frames");
    for (int f = 0; f < 4; f++) begin
      randomPhases();
      applyStimulus(4'(($urandom)), 2'(($urandom)));
      waitDone();
    end

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
